// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: latches rising edges on the interrupt request lines,
// picks the lowest-numbered unmasked pending source, and steps the core
// through interrupt entry (drain, push PC, push flags, load vector) before
// parking in SERVICE until the handler executes rti.
module interrupt_sequencer #(
  parameter int                 NUM_SRC  = 4,
  parameter int                 ID_W     = 2,
  parameter int                 VEC_W    = 32,
  parameter logic [VEC_W-1:0]   VEC_BASE = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   int_req,
  input  logic [NUM_SRC-1:0]   int_mask,
  input  logic                 pipe_idle,
  input  logic                 mem_ready,
  input  logic                 rti,
  output logic [3:0]           out,
  output logic [ID_W-1:0]      int_id,
  output logic [VEC_W-1:0]     vec_addr,
  output logic                 int_ack,
  output logic                 in_service
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DRAIN    = 3'd1;
  localparam logic [2:0] S_PUSH_PC  = 3'd2;
  localparam logic [2:0] S_PUSH_FLG = 3'd3;
  localparam logic [2:0] S_LOAD_VEC = 3'd4;
  localparam logic [2:0] S_SERVICE  = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [NUM_SRC-1:0] r_req_q;
  logic [NUM_SRC-1:0] r_pending;
  logic [ID_W-1:0]    r_int_id;
  logic [VEC_W-1:0]   r_vec_addr;

  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_eligible;
  logic               w_any;
  logic [ID_W-1:0]    w_sel;
  logic [VEC_W-1:0]   w_vec_next;
  logic               w_capture;

  // A request is a 0->1 transition seen against last cycle's sampled lines,
  // so a line held high only ever produces one pending event.
  assign w_set = int_req & ~r_req_q;

  // The serviced source is retired on the edge that leaves LOAD_VEC.
  assign w_clr = (r_state == S_LOAD_VEC) ? (NUM_SRC'(1) << r_int_id) : '0;

  // Only registered pending bits compete; a fresh edge waits one cycle.
  assign w_eligible = r_pending & int_mask;

  assign w_capture  = (r_state == S_IDLE) && w_any;
  assign w_vec_next = VEC_BASE + (VEC_W'(w_sel) << 2);

  // Fixed-priority pick: scanning downward lets the lowest index win.
  always_comb begin
    w_any = |w_eligible;
    w_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_sel = ID_W'(i);
      end
    end
  end

  // Sample request lines and accumulate pending bits; a new edge beats a
  // same-cycle acknowledge clear so no request is ever dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_req_q   <= int_req;
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  // Latch the winning source and its handler address; they hold until the
  // next capture so the handler can read them throughout SERVICE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_id   <= '0;
      r_vec_addr <= '0;
    end else if (w_capture) begin
      r_int_id   <= w_sel;
      r_vec_addr <= w_vec_next;
    end
  end

  // Entry sequence: each step waits on its handshake, LOAD_VEC lasts exactly
  // one cycle, and only SERVICE listens to rti (no nesting).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_any)     w_state_next = S_DRAIN;
      S_DRAIN:    if (pipe_idle) w_state_next = S_PUSH_PC;
      S_PUSH_PC:  if (mem_ready) w_state_next = S_PUSH_FLG;
      S_PUSH_FLG: if (mem_ready) w_state_next = S_LOAD_VEC;
      S_LOAD_VEC:                w_state_next = S_SERVICE;
      S_SERVICE:  if (rti)       w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Moore decode of the step code and status strobes from the state alone.
  always_comb begin
    out        = 4'b0000;
    int_ack    = 1'b0;
    in_service = 1'b0;
    case (r_state)
      S_DRAIN:    out = 4'b0001;
      S_PUSH_PC:  out = 4'b0011;
      S_PUSH_FLG: out = 4'b0111;
      S_LOAD_VEC: begin
        out     = 4'b1000;
        int_ack = 1'b1;
      end
      S_SERVICE:  in_service = 1'b1;
      default:    out = 4'b0000;
    endcase
  end

  assign int_id   = r_int_id;
  assign vec_addr = r_vec_addr;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: vector table plus hand-written corner sequences.
// Each applied vector pushes its expected outputs onto a queue; the entry is
// popped and compared just after the clock edge that produces the result.
module tb_interrupt_sequencer;

  typedef struct packed {
    logic [3:0]  eOut;
    logic [1:0]  eId;
    logic [31:0] eVec;
    logic        eAck;
    logic        eSvc;
  } exp_t;

  typedef struct packed {
    logic       rstN;
    logic [3:0] req;
    logic [3:0] mask;
    logic       pipeIdle;
    logic       memReady;
    logic       rtiIn;
    exp_t       exp;
  } vec_t;

  logic        clock;
  logic        rstN;
  logic [3:0]  intReq;
  logic [3:0]  intMask;
  logic        pipeIdle;
  logic        memReady;
  logic        rtiIn;
  logic [3:0]  stepOut;
  logic [1:0]  intId;
  logic [31:0] vecAddr;
  logic        intAck;
  logic        inService;

  int   checks = 0;
  int   errors = 0;
  int   stepNum = 0;
  exp_t expQ[$];
  vec_t tbl[$];

  interrupt_sequencer #(
    .NUM_SRC (4),
    .ID_W    (2),
    .VEC_W   (32),
    .VEC_BASE(32'h0000_0100)
  ) dut (
    .clk       (clock),
    .rst       (rstN),
    .int_req   (intReq),
    .int_mask  (intMask),
    .pipe_idle (pipeIdle),
    .mem_ready (memReady),
    .rti       (rtiIn),
    .out       (stepOut),
    .int_id    (intId),
    .vec_addr  (vecAddr),
    .int_ack   (intAck),
    .in_service(inService)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic r, input logic [3:0] req, input logic [3:0] mask,
                              input logic pi, input logic mr, input logic rt,
                              input logic [3:0] eOut, input logic [1:0] eId,
                              input logic [31:0] eVec, input logic eAck, input logic eSvc);
    vec_t v;
    v.rstN     = r;
    v.req      = req;
    v.mask     = mask;
    v.pipeIdle = pi;
    v.memReady = mr;
    v.rtiIn    = rt;
    v.exp.eOut = eOut;
    v.exp.eId  = eId;
    v.exp.eVec = eVec;
    v.exp.eAck = eAck;
    v.exp.eSvc = eSvc;
    return v;
  endfunction

  // Pop the oldest expectation and compare every output field against it.
  task automatic checkOutput(input int tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL step %0d scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = expQ.pop_front();
    checks++;
    if (stepOut !== e.eOut) begin
      errors++;
      $display("[TB] FAIL step %0d out: got %b expected %b", tag, stepOut, e.eOut);
    end
    checks++;
    if (intId !== e.eId) begin
      errors++;
      $display("[TB] FAIL step %0d int_id: got %0d expected %0d", tag, intId, e.eId);
    end
    checks++;
    if (vecAddr !== e.eVec) begin
      errors++;
      $display("[TB] FAIL step %0d vec_addr: got %h expected %h", tag, vecAddr, e.eVec);
    end
    checks++;
    if (intAck !== e.eAck) begin
      errors++;
      $display("[TB] FAIL step %0d int_ack: got %b expected %b", tag, intAck, e.eAck);
    end
    checks++;
    if (inService !== e.eSvc) begin
      errors++;
      $display("[TB] FAIL step %0d in_service: got %b expected %b", tag, inService, e.eSvc);
    end
  endtask

  // Drive one vector on the falling edge, then check just after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    rstN     = v.rstN;
    intReq   = v.req;
    intMask  = v.mask;
    pipeIdle = v.pipeIdle;
    memReady = v.memReady;
    rtiIn    = v.rtiIn;
    expQ.push_back(v.exp);
    @(posedge clock);
    #1;
    stepNum++;
    checkOutput(stepNum);
  endtask

  task automatic step(input logic r, input logic [3:0] req, input logic [3:0] mask,
                      input logic pi, input logic mr, input logic rt,
                      input logic [3:0] eOut, input logic [1:0] eId,
                      input logic [31:0] eVec, input logic eAck, input logic eSvc);
    applyStimulus(mk(r, req, mask, pi, mr, rt, eOut, eId, eVec, eAck, eSvc));
  endtask

  initial begin
    rstN     = 1'b0;
    intReq   = 4'h0;
    intMask  = 4'hF;
    pipeIdle = 1'b1;
    memReady = 1'b1;
    rtiIn    = 1'b0;

    // Reset with toggling requests, then release with lines low.
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0, 0, 0));
    // Single request on source 2, line held high throughout.
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0,   0, 0));
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 0, 4'b0001, 2'd2, 32'h108, 0, 0));
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 0, 4'b0011, 2'd2, 32'h108, 0, 0));
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 0, 4'b0111, 2'd2, 32'h108, 0, 0));
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 0, 4'b1000, 2'd2, 32'h108, 1, 0));
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 0, 4'b0000, 2'd2, 32'h108, 0, 1));
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 0, 4'b0000, 2'd2, 32'h108, 0, 1));
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 1, 4'b0000, 2'd2, 32'h108, 0, 0));
    tbl.push_back(mk(1, 4'h4, 4'hF, 1, 1, 0, 4'b0000, 2'd2, 32'h108, 0, 0));
    // Simultaneous edges on sources 3 and 1: 1 first, 3 after rti.
    tbl.push_back(mk(1, 4'hA, 4'hF, 1, 1, 0, 4'b0000, 2'd2, 32'h108, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0001, 2'd1, 32'h104, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0011, 2'd1, 32'h104, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0111, 2'd1, 32'h104, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b1000, 2'd1, 32'h104, 1, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd1, 32'h104, 0, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 1, 4'b0000, 2'd1, 32'h104, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0001, 2'd3, 32'h10C, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0011, 2'd3, 32'h10C, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0111, 2'd3, 32'h10C, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b1000, 2'd3, 32'h10C, 1, 0));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd3, 32'h10C, 0, 1));
    tbl.push_back(mk(1, 4'h0, 4'hF, 1, 1, 1, 4'b0000, 2'd3, 32'h10C, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
    end

    // Handshake stalls: 0001 for five cycles, 0011 for four.
    step(1, 4'h4, 4'hF, 0, 1, 0, 4'b0000, 2'd3, 32'h10C, 0, 0);
    step(1, 4'h0, 4'hF, 0, 1, 0, 4'b0001, 2'd2, 32'h108, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 4'h0, 4'hF, 0, 1, 0, 4'b0001, 2'd2, 32'h108, 0, 0);
    step(1, 4'h0, 4'hF, 1, 0, 0, 4'b0011, 2'd2, 32'h108, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'h0, 4'hF, 1, 0, 0, 4'b0011, 2'd2, 32'h108, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0111, 2'd2, 32'h108, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b1000, 2'd2, 32'h108, 1, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd2, 32'h108, 0, 1);
    step(1, 4'h0, 4'hF, 1, 1, 1, 4'b0000, 2'd2, 32'h108, 0, 0);

    // Masked source 0 is retained, then serviced once unmasked.
    step(1, 4'h1, 4'hE, 1, 1, 0, 4'b0000, 2'd2, 32'h108, 0, 0);
    step(1, 4'h0, 4'hE, 1, 1, 0, 4'b0000, 2'd2, 32'h108, 0, 0);
    step(1, 4'h0, 4'hE, 1, 1, 0, 4'b0000, 2'd2, 32'h108, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0001, 2'd0, 32'h100, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0011, 2'd0, 32'h100, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0111, 2'd0, 32'h100, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b1000, 2'd0, 32'h100, 1, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h100, 0, 1);
    step(1, 4'h0, 4'hF, 1, 1, 1, 4'b0000, 2'd0, 32'h100, 0, 0);

    // Abort in PUSH_FLG with source 3 still pending.
    step(1, 4'hA, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h100, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0001, 2'd1, 32'h104, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0011, 2'd1, 32'h104, 0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0111, 2'd1, 32'h104, 0, 0);
    @(negedge clock);
    rstN = 1'b0;
    expQ.push_back('{eOut: 4'b0000, eId: 2'd0, eVec: 32'h0, eAck: 1'b0, eSvc: 1'b0});
    #1;
    stepNum++;
    checkOutput(stepNum);
    step(0, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0, 0, 0);

    // Stray rti in IDLE changes nothing; a fresh edge still works.
    step(1, 4'h0, 4'hF, 1, 1, 1, 4'b0000, 2'd0, 32'h0,   0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0,   0, 0);
    step(1, 4'h8, 4'hF, 1, 1, 0, 4'b0000, 2'd0, 32'h0,   0, 0);
    step(1, 4'h0, 4'hF, 1, 1, 0, 4'b0001, 2'd3, 32'h10C, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
